mem_arbiter: RTL and testbench

//  Shares the single main-memory port between two cache clients: port 0 = dcache, port 1 = icache.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client main-memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int DEF_ADDR_BITS = 28;
  localparam int DEF_DATA_BITS = MEM_DATA_BITS;
  localparam int DEF_BEATS     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RRESP = 2'd3
  } state_t;

  // Round-robin pick: a lone requester wins; on a tie the client that did not win last time goes.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the main-memory port between dcache (client 0) and icache (client 1).
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no transaction; a new grant is taken here only
//  ST_REQ   | granted client's request presented on the memory port
//  ST_WDATA | forwarding BEATS write-data beats from the granted client
//  ST_RRESP | routing BEATS read-response beats to the granted client
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int BEATS     = DEF_BEATS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c0_req_valid,
  output logic                   c0_req_ready,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic                   c0_req_rw,
  input  logic                   c0_req_data_valid,
  output logic                   c0_req_data_ready,
  input  logic [DATA_BITS-1:0]   c0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
  output logic                   c0_resp_valid,
  output logic [DATA_BITS-1:0]   c0_resp_data,
  input  logic                   c1_req_valid,
  output logic                   c1_req_ready,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic                   c1_req_rw,
  input  logic                   c1_req_data_valid,
  output logic                   c1_req_data_ready,
  input  logic [DATA_BITS-1:0]   c1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
  output logic                   c1_resp_valid,
  output logic [DATA_BITS-1:0]   c1_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic                   protocol_err
);

  localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  state_t              state, state_nxt;
  logic                grant, grant_nxt;
  logic                last_grant, last_grant_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;

  logic                   g_valid, g_rw, g_dvalid;
  logic [ADDR_BITS-1:0]   g_addr;
  logic [DATA_BITS-1:0]   g_dbits;
  logic [DATA_BITS/8-1:0] g_dmask;

  // Granted client's request and write-data fields.
  always_comb begin
    g_valid  = grant ? c1_req_valid      : c0_req_valid;
    g_rw     = grant ? c1_req_rw         : c0_req_rw;
    g_addr   = grant ? c1_req_addr       : c0_req_addr;
    g_dvalid = grant ? c1_req_data_valid : c0_req_data_valid;
    g_dbits  = grant ? c1_req_data_bits  : c0_req_data_bits;
    g_dmask  = grant ? c1_req_data_mask  : c0_req_data_mask;
  end

  // State, grant, round-robin history and beat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Next-state and output decode; every output is idle-low unless its phase is active.
  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    last_grant_nxt     = last_grant;
    cnt_nxt            = cnt;
    c0_req_ready       = 1'b0;
    c1_req_ready       = 1'b0;
    c0_req_data_ready  = 1'b0;
    c1_req_data_ready  = 1'b0;
    c0_resp_valid      = 1'b0;
    c1_resp_valid      = 1'b0;
    c0_resp_data       = '0;
    c1_resp_data       = '0;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    case (state)
      ST_IDLE: begin
        if (c0_req_valid || c1_req_valid) begin
          grant_nxt = rr_pick(c0_req_valid, c1_req_valid, last_grant);
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = g_valid;
        mem_req_addr  = g_addr;
        mem_req_rw    = g_rw;
        c0_req_ready  = ~grant & mem_req_ready;
        c1_req_ready  = grant & mem_req_ready;
        if (!g_valid) begin
          // Client withdrew: history is left alone so it keeps its turn.
          state_nxt = ST_IDLE;
        end else if (mem_req_ready) begin
          last_grant_nxt = grant;
          cnt_nxt        = '0;
          state_nxt      = g_rw ? ST_WDATA : ST_RRESP;
        end
      end
      ST_WDATA: begin
        mem_req_data_valid = g_dvalid;
        mem_req_data_bits  = g_dbits;
        mem_req_data_mask  = g_dmask;
        c0_req_data_ready  = ~grant & mem_req_data_ready;
        c1_req_data_ready  = grant & mem_req_data_ready;
        if (g_dvalid && mem_req_data_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_RRESP: begin
        c0_resp_valid = ~grant & mem_resp_valid;
        c1_resp_valid = grant & mem_resp_valid;
        c0_resp_data  = mem_resp_data;
        c1_resp_data  = mem_resp_data;
        if (mem_resp_valid) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sticky flag for a response beat arriving when no read is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_err <= 1'b0;
    end else if (mem_resp_valid && (state != ST_RRESP)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus hand sequences for stray beats and mid-read reset.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam logic [AB-1:0] C0_ADDR = 28'h0ABCDEF;
  localparam logic [AB-1:0] C1_ADDR = 28'h0000123;

  logic clk, reset_n;
  logic c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready, c0_resp_valid;
  logic c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready, c1_resp_valid;
  logic [AB-1:0] c0_req_addr, c1_req_addr, mem_req_addr;
  logic [DB-1:0] c0_req_data_bits, c1_req_data_bits, c0_resp_data, c1_resp_data;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [DB/8-1:0] c0_req_data_mask, c1_req_data_mask, mem_req_data_mask;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic mem_resp_valid, protocol_err;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
    .c0_req_rw(c0_req_rw), .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
    .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
    .c1_req_rw(c1_req_rw), .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
    .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in : {c0v, c0rw, c1v, c1rw, c0dv, c1dv, mem_rdy, mem_drdy, mem_rv}
  // exp: {mv, mrw, asel[1:0], c0r, c1r, mdv, c0dr, c1dr, c0rv, c1rv, perr}
  //      asel: 0 = addr not checked, 1 = c0 address, 2 = c1 address
  typedef struct {
    logic [8:0]  in;
    logic [7:0]  dat;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic add(input logic [8:0] i, input logic [7:0] d, input logic [11:0] e);
    vec_t v;
    v.in = i; v.dat = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] i, input logic [7:0] d);
    {c0_req_valid, c0_req_rw, c1_req_valid, c1_req_rw, c0_req_data_valid, c1_req_data_valid,
     mem_req_ready, mem_req_data_ready, mem_resp_valid} = i;
    c0_req_data_bits = {16{~d}};
    c1_req_data_bits = {16{d}};
    mem_resp_data    = {16{d}};
  endtask

  task automatic hstep(input logic [8:0] i, input logic [7:0] d);
    @(negedge clk);
    drive(i, d);
    #1;
    n_vec++;
  endtask

  task automatic chk_all_low(input string nm, input int idx);
    chk({nm, "_mv"},  idx, DB'(mem_req_valid), '0);
    chk({nm, "_mdv"}, idx, DB'(mem_req_data_valid), '0);
    chk({nm, "_c0r"}, idx, DB'(c0_req_ready), '0);
    chk({nm, "_c1r"}, idx, DB'(c1_req_ready), '0);
    chk({nm, "_c0rv"}, idx, DB'(c0_resp_valid), '0);
    chk({nm, "_c1rv"}, idx, DB'(c1_resp_valid), '0);
  endtask

  initial begin
    c0_req_addr = C0_ADDR;  c1_req_addr = C1_ADDR;
    c0_req_data_mask = 16'hF000;  c1_req_data_mask = 16'h000F;
    drive(9'b0, 8'h00);
    reset_n = 1'b0;

    // tie after reset (c0 first), c0 read A0..A3, tie -> c1, tie -> c0
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b1_0_01_1_0_0_0_0_0_0_0);
    for (int k = 0; k < 4; k++)
      add(9'b0_0_1_0_0_0_1_0_1, 8'hA0 + 8'(k), 12'b0_0_00_0_0_0_0_0_1_0_0);
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b1_0_10_0_1_0_0_0_0_0_0);
    for (int k = 0; k < 4; k++)
      add(9'b1_0_0_0_0_0_1_0_1, 8'hB0 + 8'(k), 12'b0_0_00_0_0_0_0_0_0_1_0);
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b1_0_1_0_0_0_1_0_0, 8'h00, 12'b1_0_01_1_0_0_0_0_0_0_0);
    for (int k = 0; k < 4; k++)
      add(9'b0_0_0_0_0_0_1_0_1, 8'hC0 + 8'(k), 12'b0_0_00_0_0_0_0_0_1_0_0);
    add(9'b0, 8'h00, 12'b0);
    // c1 write stalled 5 cycles on mem_req_ready, then 4 beats with toggling data ready
    add(9'b1_0_1_1_0_0_0_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    for (int k = 0; k < 5; k++)
      add(9'b1_0_1_1_0_0_0_0_0, 8'h00, 12'b1_1_10_0_0_0_0_0_0_0_0);
    add(9'b1_0_1_1_0_0_1_0_0, 8'h00, 12'b1_1_10_0_1_0_0_0_0_0_0);
    add(9'b1_0_0_0_0_1_0_1_0, 8'hD0, 12'b0_0_00_0_0_1_0_1_0_0_0);
    for (int k = 1; k < 4; k++) begin
      add(9'b1_0_0_0_0_1_0_0_0, 8'hD0 + 8'(k), 12'b0_0_00_0_0_1_0_0_0_0_0);
      add(9'b1_0_0_0_0_1_0_1_0, 8'hD0 + 8'(k), 12'b0_0_00_0_0_1_0_1_0_0_0);
    end
    // c0 granted then withdraws; history unchanged so next tie still goes to c0
    add(9'b1_0_0_0_0_0_0_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b0, 8'h00, 12'b0_0_01_0_0_0_0_0_0_0_0);
    add(9'b0, 8'h00, 12'b0);
    add(9'b1_0_1_0_0_0_0_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b1_0_1_0_0_0_0_0_0, 8'h00, 12'b1_0_01_0_0_0_0_0_0_0_0);
    add(9'b0_0_1_0_0_0_0_0_0, 8'h00, 12'b0_0_01_0_0_0_0_0_0_0_0);
    add(9'b0_0_1_0_0_0_0_0_0, 8'h00, 12'b0_0_00_0_0_0_0_0_0_0_0);
    add(9'b0, 8'h00, 12'b0_0_10_0_0_0_0_0_0_0_0);
    add(9'b0, 8'h00, 12'b0);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    chk_all_low("rst", -1);
    chk("rst_perr", -1, DB'(protocol_err), '0);
    chk("rst_c0rd", -1, c0_resp_data, '0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[n]) begin
      logic [11:0] e;
      logic [127:0] exp_addr;
      @(negedge clk);
      drive(tbl[n].in, tbl[n].dat);
      #1;
      n_vec++;
      e = tbl[n].exp;
      chk("mv",   n, DB'(mem_req_valid),      DB'(e[11]));
      chk("c0r",  n, DB'(c0_req_ready),       DB'(e[7]));
      chk("c1r",  n, DB'(c1_req_ready),       DB'(e[6]));
      chk("mdv",  n, DB'(mem_req_data_valid), DB'(e[5]));
      chk("c0dr", n, DB'(c0_req_data_ready),  DB'(e[4]));
      chk("c1dr", n, DB'(c1_req_data_ready),  DB'(e[3]));
      chk("c0rv", n, DB'(c0_resp_valid),      DB'(e[2]));
      chk("c1rv", n, DB'(c1_resp_valid),      DB'(e[1]));
      chk("perr", n, DB'(protocol_err),       DB'(e[0]));
      if (e[11]) chk("mrw", n, DB'(mem_req_rw), DB'(e[10]));
      if (e[9:8] != 2'd0) begin
        exp_addr = (e[9:8] == 2'd1) ? DB'(C0_ADDR) : DB'(C1_ADDR);
        chk("maddr", n, DB'(mem_req_addr), exp_addr);
      end
      if (e[5]) begin
        chk("mdata", n, mem_req_data_bits, {16{tbl[n].dat}});
        chk("mmask", n, DB'(mem_req_data_mask), DB'(16'h000F));
      end
      if (e[2] || e[1]) begin
        chk("c0rd", n, c0_resp_data, {16{tbl[n].dat}});
        chk("c1rd", n, c1_resp_data, {16{tbl[n].dat}});
      end
    end

    // stray response beat in IDLE: dropped, sticky error
    hstep(9'b0_0_0_0_0_0_0_0_1, 8'h77);
    chk_all_low("stray", 0);
    chk("stray_perr0", 0, DB'(protocol_err), '0);
    hstep(9'b0, 8'h00);
    chk("stray_perr1", 1, DB'(protocol_err), DB'(1'b1));
    repeat (3) hstep(9'b0, 8'h00);
    chk("stray_perr_sticky", 4, DB'(protocol_err), DB'(1'b1));

    // reset during beat 2 of a c0 read
    hstep(9'b1_0_0_0_0_0_1_0_0, 8'h00);
    hstep(9'b1_0_0_0_0_0_1_0_0, 8'h00);
    chk("rr_mv", 0, DB'(mem_req_valid), DB'(1'b1));
    hstep(9'b0_0_0_0_0_0_1_0_1, 8'h10);
    hstep(9'b0_0_0_0_0_0_1_0_1, 8'h11);
    hstep(9'b0_0_0_0_0_0_1_0_1, 8'h12);
    chk("rr_beat2_rv", 2, DB'(c0_resp_valid), DB'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    chk_all_low("rr_async", 3);
    chk("rr_async_perr", 3, DB'(protocol_err), '0);
    chk("rr_async_c0rd", 3, c0_resp_data, '0);
    @(negedge clk);
    drive(9'b0, 8'h00);
    reset_n = 1'b1;

    // fresh c0 read after reset
    hstep(9'b1_0_0_0_0_0_1_0_0, 8'h00);
    chk_all_low("fr_idle", 0);
    hstep(9'b1_0_0_0_0_0_1_0_0, 8'h00);
    chk("fr_mv", 1, DB'(mem_req_valid), DB'(1'b1));
    chk("fr_addr", 1, DB'(mem_req_addr), DB'(C0_ADDR));
    chk("fr_c0r", 1, DB'(c0_req_ready), DB'(1'b1));
    for (int k = 0; k < 4; k++) begin
      hstep(9'b0_0_0_0_0_0_1_0_1, 8'h20 + 8'(k));
      chk("fr_c0rv", 2 + k, DB'(c0_resp_valid), DB'(1'b1));
      chk("fr_c1rv", 2 + k, DB'(c1_resp_valid), '0);
      chk("fr_c0rd", 2 + k, c0_resp_data, {16{8'h20 + 8'(k)}});
    end
    hstep(9'b0, 8'h00);
    chk_all_low("fr_done", 6);
    chk("fr_perr", 6, DB'(protocol_err), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
